ascon_hash_stream_ctrl: RTL and testbench
=========================================

Name: ascon_hash_stream_ctrl

Overview:
- Byte-stream front/back end for the Ascon hash core.
- Collects a fixed-length message from an 8-bit valid/ready input stream and presents it as a parallel word on the core's message input.
- Pulses the core's start, waits for digest ready, captures the digest and streams it out MSB byte first on an 8-bit valid/ready output.
- Re-arms the core (second start pulse from its DONE state) before accepting the next message.

Parameters:
- Y_BITS, 40, message width in bits; must equal the core's y; multiple of 8, >= 8.
- L_BITS, 256, digest width in bits; must equal the core's l; multiple of 8.
- NB_IN, Y_BITS/8, derived; message byte count.
- NB_OUT, L_BITS/8, derived; digest byte count.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk.
- in_data  in  8  message byte
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts a byte this cycle
- msg  out  Y_BITS  parallel message to the core's message input
- hash_start  out  1  start pulse to the core
- hash_ready  in  1  core ready (digest valid while high)
- hash_in  in  L_BITS  core digest output
- out_data  out  8  digest byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in every state except LOAD

Behaviour:
- All outputs are decoded from registered state. No combinational path from in_valid or out_ready to any output.
- Reset:
  - state=LOAD, msg=0, digest register=0, byte counter=0.
  - First cycle after rst deasserts: in_ready=1, out_valid=0, hash_start=0, busy=0.
  - rst asserted in any state, including mid-DRAIN or WAIT, aborts immediately; the partial digest is discarded.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: msg <= {msg[Y_BITS-9:0], in_data}, cnt++. The first byte received ends in msg[Y_BITS-1 -: 8].
  - When the accepted byte is number NB_IN (cnt==NB_IN-1): cnt<=0, go to START.
  - Gaps in in_valid are allowed; the counter holds.
- START: hash_start=1 for exactly one cycle, in_ready=0 -> WAIT.
- WAIT:
  - hash_start=0.
  - msg is held stable; the core reads msg combinationally throughout absorb. msg changes only in LOAD.
  - When hash_ready==1: digest <= hash_in -> DRAIN.
  - No timeout.
- DRAIN:
  - out_valid=1, out_data=digest[L_BITS-1 -: 8].
  - On out_valid&&out_ready: digest <= digest<<8, cnt++.
  - out_data is stable while out_valid&&!out_ready.
  - After byte NB_OUT is accepted: cnt<=0 -> RELEASE. out_valid drops the next cycle.
- RELEASE: hash_start=1 for one cycle; returns the core from DONE to IDLE -> SETTLE.
- SETTLE:
  - Wait for hash_ready==0. The core holds ready high for at least one cycle after the release start.
  - Then -> LOAD.
  - Any in_valid during SETTLE is not accepted (in_ready=0).
- hash_start is never high for two consecutive cycles. It is high only in START and RELEASE.
- Counter width: $clog2(max(NB_IN,NB_OUT)). Never wraps, because it is cleared at each phase end.
- Minimum turnaround, message-last-byte to next in_ready: 1 (START) + core latency + NB_OUT (with out_ready=1) + 1 (RELEASE) + >=2 (SETTLE) cycles.
- Simultaneous events:
  - hash_ready high on the first WAIT cycle is accepted.
  - in_valid asserted in the same cycle rst deasserts is not accepted, because in_ready is low during reset.

Decomposition:
- Shared package ascon_hash_pkg holds:
  - state encoding (LOAD, START, WAIT, DRAIN, RELEASE, SETTLE; 3-bit);
  - the byte-count derivation functions;
  - default Y_BITS/L_BITS constants, shared with the hash core instantiation.
- No sub-module: both shift registers and the counter are inline. A top-level wrapper instantiates this block alongside the hash core.

Test Plan:
1. Y_BITS=40, bytes 01,02,03,04,05 with in_valid continuous -> msg=0x0102030405 on cycle after last accept; hash_start single-cycle pulse; in_ready=0 until SETTLE exits.
2. Stub core raises hash_ready 30 cycles after start with hash_in=0x00112233..EEFF repeated -> out bytes 00,11,22,... in order, exactly 32 bytes, then one RELEASE pulse on hash_start.
3. out_ready toggled 1,0,0,1 pattern -> out_data held constant across stalls, no byte lost or duplicated, byte count 32.
4. in_valid with random 0-3 cycle gaps -> msg identical to scenario 1; msg unchanged during entire WAIT while in_valid keeps toggling.
5. rst pulse after 10th digest byte -> next cycle out_valid=0, in_ready=1, msg=0; following message processes normally from byte 1.
6. Real Ascon core, two back-to-back messages -> second start only after core ready dropped; both digests match the Ascon-Hash reference model output for the respective messages.

Source files
------------

// File: rtl/ascon_hash_pkg.sv
// Shared definitions for the Ascon hash stream controller and its core instantiation:
// FSM encoding, byte-count helpers and the default message/digest widths.
package ascon_hash_pkg;

  localparam int Y_BITS_DEF = 40;
  localparam int L_BITS_DEF = 256;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SETTLE  = 3'd5
  } hash_state_e;

  function automatic int nbytes(input int bits);
    return bits / 8;
  endfunction

  // One counter serves both phases, so it is sized for the longer one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ascon_hash_stream_ctrl.sv
// Byte-stream wrapper around the Ascon hash core: gathers the message, starts the core,
// streams the digest out MSB byte first, then re-arms the core before the next message.
module ascon_hash_stream_ctrl
  import ascon_hash_pkg::*;
#(
  parameter int Y_BITS = Y_BITS_DEF,
  parameter int L_BITS = L_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [Y_BITS-1:0] msg,
  output logic              hash_start,
  input  logic              hash_ready,
  input  logic [L_BITS-1:0] hash_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int NB_IN  = nbytes(Y_BITS);
  localparam int NB_OUT = nbytes(L_BITS);
  localparam int CW     = cnt_width(NB_IN, NB_OUT);
  localparam logic [CW-1:0] LAST_IN  = CW'(NB_IN - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NB_OUT - 1);

  hash_state_e       r_state;
  hash_state_e       w_state_nxt;
  logic [Y_BITS-1:0] r_msg;
  logic [L_BITS-1:0] r_digest;
  logic [CW-1:0]     r_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_last_in;
  logic w_last_out;

  // in_ready is held low while rst is asserted so a byte offered on the reset cycle is dropped.
  assign w_in_ready  = (r_state == ST_LOAD) && !rst;
  assign w_out_valid = (r_state == ST_DRAIN);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_last_in   = (r_cnt == LAST_IN);
  assign w_last_out  = (r_cnt == LAST_OUT);

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = r_digest[L_BITS-1 -: 8];
  assign msg        = r_msg;
  assign hash_start = (r_state == ST_START) || (r_state == ST_RELEASE);
  assign busy       = (r_state != ST_LOAD);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire && w_last_in) w_state_nxt = ST_START;
        else                        w_state_nxt = ST_LOAD;
      end
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (hash_ready) w_state_nxt = ST_DRAIN;
        else            w_state_nxt = ST_WAIT;
      end
      ST_DRAIN: begin
        if (w_out_fire && w_last_out) w_state_nxt = ST_RELEASE;
        else                          w_state_nxt = ST_DRAIN;
      end
      ST_RELEASE: w_state_nxt = ST_SETTLE;
      // The core keeps ready high briefly after the release pulse; wait for it to drop.
      ST_SETTLE: begin
        if (!hash_ready) w_state_nxt = ST_LOAD;
        else             w_state_nxt = ST_SETTLE;
      end
      default:    w_state_nxt = ST_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  // Message shift register; only moves in LOAD so the core sees a stable word while absorbing.
  always_ff @(posedge clk) begin
    if (rst)            r_msg <= {Y_BITS{1'b0}};
    else if (w_in_fire) r_msg <= (r_msg << 8) | Y_BITS'(in_data);
    else                r_msg <= r_msg;
  end

  // Digest capture and MSB-first output shift
  always_ff @(posedge clk) begin
    if (rst)                                  r_digest <= {L_BITS{1'b0}};
    else if ((r_state == ST_WAIT) && hash_ready) r_digest <= hash_in;
    else if (w_out_fire)                      r_digest <= r_digest << 8;
    else                                      r_digest <= r_digest;
  end

  // Shared byte counter, cleared at the end of each phase
  always_ff @(posedge clk) begin
    if (rst)             r_cnt <= {CW{1'b0}};
    else if (w_in_fire)  r_cnt <= w_last_in  ? {CW{1'b0}} : r_cnt + CW'(1);
    else if (w_out_fire) r_cnt <= w_last_out ? {CW{1'b0}} : r_cnt + CW'(1);
    else                 r_cnt <= r_cnt;
  end

endmodule

// File: tb/tb_ascon_hash_stream_ctrl.sv
// Scoreboard bench for ascon_hash_stream_ctrl with a behavioural stand-in for the hash core
// (fixed 30-cycle latency, message-dependent digest, ready held one cycle past release).
module tb_ascon_hash_stream_ctrl;

  localparam int Y = 40;
  localparam int L = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [Y-1:0] msg;
  logic         hash_start;
  logic         hash_ready;
  logic [L-1:0] hash_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  ascon_hash_stream_ctrl #(.Y_BITS(Y), .L_BITS(L)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .msg(msg), .hash_start(hash_start), .hash_ready(hash_ready), .hash_in(hash_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_start = 0;
  logic [7:0] exp_q[$];
  logic [Y-1:0] exp_msg = '0;
  logic hold_chk = 1'b0;
  int or_mode = 0;

  task automatic chk(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Digest produced by the stand-in core: 00,11,..,FF twice, low bits mixed with the message.
  function automatic logic [L-1:0] stub_digest(input logic [Y-1:0] m);
    logic [L-1:0] d;
    for (int i = 0; i < 32; i++) d[L-1-8*i -: 8] = 8'(8'h11 * (i % 16));
    return d ^ {216'd0, m};
  endfunction

  // Stand-in hash core
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_REL = 2'd3;
  logic [1:0]   stub_st;
  int           stub_cnt;
  logic [Y-1:0] stub_msg;
  always @(posedge clk) begin
    if (rst) begin
      stub_st <= S_IDLE; hash_ready <= 1'b0; hash_in <= '0; stub_cnt <= 0; stub_msg <= '0;
    end else begin
      case (stub_st)
        S_IDLE: if (hash_start) begin stub_st <= S_RUN; stub_cnt <= 29; stub_msg <= msg; end
        S_RUN: begin
          if (stub_cnt == 0) begin
            hash_ready <= 1'b1; hash_in <= stub_digest(stub_msg); stub_st <= S_DONE;
          end else stub_cnt <= stub_cnt - 1;
        end
        S_DONE: if (hash_start) stub_st <= S_REL;
        default: begin hash_ready <= 1'b0; stub_st <= S_IDLE; end
      endcase
    end
  end

  // Downstream back-pressure: always ready, 1,0,0,1 pattern, or random
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001; k = 0; out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[k]; k = (k + 1) % 4; end
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, start-pulse rules, message hold
  logic prev_stall = 1'b0, prev_start = 1'b0;
  logic [7:0] prev_data = 8'd0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", {255'd0, out_valid}, '0);
      else begin
        e = exp_q.pop_front();
        chk("dig_byte", {248'd0, out_data}, {248'd0, e});
        n_pop++;
      end
    end
    if (out_valid && prev_stall) chk("stall_hold", {248'd0, out_data}, {248'd0, prev_data});
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (hash_start) begin
      chk("start_single", {255'd0, prev_start}, '0);
      if (stub_st == S_IDLE) chk("start_rdy_low", {255'd0, hash_ready}, '0);
      n_start++;
    end
    prev_start = hash_start;
    if (hold_chk) chk("msg_hold", {216'd0, msg}, {216'd0, exp_msg});
  end

  task automatic send_msg(input logic [Y-1:0] m, input int max_gap);
    logic [L-1:0] d;
    int t, g;
    n_start = 0;
    for (int i = 0; i < 5; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) @(negedge clk);
      in_data = m[Y-1-8*i -: 8];
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("in_timeout", '0, 256'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("msg", {216'd0, msg}, {216'd0, m});
    chk("start_on", {255'd0, hash_start}, 256'd1);
    chk("in_ready_low", {255'd0, in_ready}, '0);
    exp_msg = m;
    hold_chk = 1'b1;
    d = stub_digest(m);
    for (int i = 0; i < 32; i++) exp_q.push_back(d[L-1-8*i -: 8]);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready && exp_q.size() == 0) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("idle_timeout", '0, 256'd1);
    hold_chk = 1'b0;
    chk("idle_busy", {255'd0, busy}, '0);
    chk("idle_out_valid", {255'd0, out_valid}, '0);
    chk("start_count", 256'(n_start), 256'd2);
  endtask

  initial begin
    int t, base;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (4) @(negedge clk);
    chk("rst_in_ready", {255'd0, in_ready}, '0);
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_msg", {216'd0, msg}, '0);
    chk("rst_in_ready1", {255'd0, in_ready}, 256'd1);
    chk("rst_out_valid", {255'd0, out_valid}, '0);
    chk("rst_start", {255'd0, hash_start}, '0);
    chk("rst_busy", {255'd0, busy}, '0);

    // continuous input, free-flowing output
    or_mode = 0;
    send_msg(40'h0102030405, 0);
    wait_idle();

    // 1,0,0,1 back-pressure
    or_mode = 1;
    send_msg(40'hA1B2C3D4E5, 0);
    wait_idle();

    // gapped input, in_valid toggling while the core works
    or_mode = 2;
    send_msg(40'h0102030405, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1, 0));
      in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    wait_idle();

    // reset in the middle of the digest stream
    or_mode = 0;
    base = n_pop;
    send_msg(40'h5566778899, 0);
    t = 0;
    while (n_pop < base + 10 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("pop_timeout", '0, 256'd1);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    hold_chk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", {255'd0, out_valid}, '0);
    chk("abort_in_ready", {255'd0, in_ready}, 256'd1);
    chk("abort_msg", {216'd0, msg}, '0);
    send_msg(40'h0A0B0C0D0E, 2);
    wait_idle();

    // back-to-back messages
    or_mode = 2;
    send_msg(40'hDEADBEEF01, 0);
    wait_idle();
    send_msg(40'h1122334455, 1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
